// File: rtl/axis_adc_pkg.sv
// axis_adc_pkg
//   Shared types and constants for the ADC-to-AXI-Stream packetizer:
//   serializer state encoding, drop counter width and a width helper.
package axis_adc_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam int DROP_CNT_W = 16;

    // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_adc_fifo.sv
// axis_adc_fifo
//   Synchronous first-word-fall-through FIFO. rd_data shows the head entry
//   whenever empty is low; rd_en pops it. A write is accepted while not full,
//   or while full if a pop happens on the same cycle.
//
// Ports
//   clk_sys  : clock
//   rst      : synchronous active-high reset, empties the FIFO
//   wr_en    : push request, wr_data : entry to push
//   full     : no free entry
//   rd_en    : pop request (ignored while empty)
//   rd_data  : head entry, empty : no entry stored
module axis_adc_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/axis_adc_packetizer.sv
// axis_adc_packetizer
//   Captures multi-channel ADC frames, serializes them one channel per cycle
//   into an FWFT FIFO and presents them as an AXI-Stream master with a
//   fixed packet length. Frames arriving while the previous one is still
//   being serialized are dropped whole and counted.
//
//   Optional build macro AXIS_ADC_TEST_PATTEN_EN: pushed samples come from
//   an internal counter that increments per pushed word instead of adc_data.
//
// Ports
//   m_axis_aclk / m_axis_areset : clock, synchronous active-high reset
//   enable, adc_valid, adc_data : frame capture interface
//   m_axis_*                    : AXI-Stream master, tuser = channel index
//   overflow, drop_count        : sticky drop flag, saturating drop count
//
// Serializer states
//   state     | meaning
//   SER_IDLE  | waiting for a frame, next adc_valid&&enable captures it
//   SER_SHIFT | pushing channel ch_q into the FIFO, stalls while it is full
module axis_adc_packetizer
    import axis_adc_pkg::*;
#(
    parameter int ADC_WIDTH   = 14,
    parameter int TDATA_WIDTH = 16,
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int PKT_LEN     = 64,
    parameter int SIGN_EXT    = 1
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_areset,
    input  logic                          enable,
    input  logic                          adc_valid,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   adc_data,
    output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]      m_axis_tstrb,
    output logic [TDATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [clog2_min1(NUM_CH)-1:0] m_axis_tuser,
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_count
);

    localparam int CH_W    = clog2_min1(NUM_CH);
    localparam int BEAT_W  = clog2_min1(PKT_LEN);
    localparam int ENTRY_W = TDATA_WIDTH + CH_W;

    ser_state_e                   state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [NUM_CH*ADC_WIDTH-1:0]  cap_q, cap_d;
    logic                         overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]        drop_q, drop_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;

    logic                         capture, drop, push, pop;
    logic [ADC_WIDTH-1:0]         push_sample;
    logic [TDATA_WIDTH-1:0]       ext_sample;
    logic                         fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]           fifo_rd_data;

    assign capture = adc_valid && enable && (state_q == SER_IDLE);
    assign drop    = adc_valid && enable && (state_q == SER_SHIFT);
    assign pop     = !fifo_empty && m_axis_tready;
    // A full FIFO still takes a word when the head leaves on the same cycle.
    assign push    = (state_q == SER_SHIFT) && (!fifo_full || pop);

`ifdef AXIS_ADC_TEST_PATTEN_EN
    logic [ADC_WIDTH-1:0] pat_q, pat_d;

    always_comb begin
        pat_d       = pat_q;
        push_sample = pat_q;
        if (push) begin
            pat_d = pat_q + ADC_WIDTH'(1);
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end
`else
    always_comb begin
        push_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                push_sample = cap_q[k*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end
`endif

    // Fill the upper bits first, then overlay the sample; this also works
    // when TDATA_WIDTH equals ADC_WIDTH.
    always_comb begin
        ext_sample = '0;
        if ((SIGN_EXT != 0) && push_sample[ADC_WIDTH-1]) begin
            ext_sample = '1;
        end
        ext_sample[ADC_WIDTH-1:0] = push_sample;
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cap_d      = cap_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        beat_d     = beat_q;

        case (state_q)
            SER_IDLE: begin
                if (capture) begin
                    state_d = SER_SHIFT;
                    ch_d    = '0;
                    cap_d   = adc_data;
                end
            end
            SER_SHIFT: begin
                if (push) begin
                    if (ch_q == CH_W'(NUM_CH-1)) begin
                        state_d = SER_IDLE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end

        if (pop) begin
            if (beat_q == BEAT_W'(PKT_LEN-1)) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q    <= SER_IDLE;
            ch_q       <= '0;
            cap_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cap_q      <= cap_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            beat_q     <= beat_d;
        end
    end

    axis_adc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (m_axis_aclk),
        .rst     (m_axis_areset),
        .wr_en   (push),
        .wr_data ({ch_q, ext_sample}),
        .full    (fifo_full),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    // Payload is forced to zero while no beat is offered so reset and idle
    // outputs are clean regardless of stale FIFO storage.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_rd_data[TDATA_WIDTH-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? fifo_rd_data[ENTRY_W-1 -: CH_W] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beat_q == BEAT_W'(PKT_LEN-1));
    assign m_axis_tstrb  = '1;
    assign m_axis_tkeep  = '1;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axis_adc_packetizer.sv
// tb_axis_adc_packetizer
//   Directed bench for axis_adc_packetizer with default parameters plus a
//   SIGN_EXT=0 instance sharing the same stimulus. Frame f carries samples
//   2f (ch0) and 2f+1 (ch1), so the accepted beat stream after a reset reads
//   0,1,2,... in both the normal and the AXIS_ADC_TEST_PATTEN_EN build.
module tb_axis_adc_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        adc_valid;
    logic [27:0] adc_data;
    logic        tready;

    logic [15:0] tdata, tdata_z;
    logic [1:0]  tstrb, tkeep, tstrb_z, tkeep_z;
    logic        tvalid, tlast, tuser, tvalid_z, tlast_z, tuser_z;
    logic        overflow, overflow_z;
    logic [15:0] drop_count, drop_count_z;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q_data [$];
    logic        q_user [$];
    logic        q_last [$];
    logic [15:0] lfsr;

    always #5 clk = ~clk;

    axis_adc_packetizer dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .enable        (enable),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .m_axis_tdata  (tdata),
        .m_axis_tstrb  (tstrb),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    axis_adc_packetizer #(.SIGN_EXT(0)) dut_z (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .enable        (enable),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .m_axis_tdata  (tdata_z),
        .m_axis_tstrb  (tstrb_z),
        .m_axis_tkeep  (tkeep_z),
        .m_axis_tvalid (tvalid_z),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast_z),
        .m_axis_tuser  (tuser_z),
        .overflow      (overflow_z),
        .drop_count    (drop_count_z)
    );

    // Inputs change at posedge+1, so the negedge sees what the next edge samples.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) begin
            q_data.push_back(tdata);
            q_user.push_back(tuser);
            q_last.push_back(tlast);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        adc_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_user.delete();
        q_last.delete();
    endtask

    function automatic logic [27:0] frame_word(input int f);
        return {14'(2*f+1), 14'(2*f)};
    endfunction

    task automatic run_frames(input int nfr, input int gap, input bit lfsr_rdy);
        for (int f = 0; f < nfr; f++) begin
            for (int c = 0; c < gap; c++) begin
                adc_valid = (c == 0);
                adc_data  = frame_word(f);
                if (lfsr_rdy) begin
                    tready = lfsr[0];
                    lfsr   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                end
                step();
            end
        end
        adc_valid = 1'b0;
        tready    = 1'b1;
        repeat (40) step();
    endtask

    task automatic check_beats(input string tag, input int n);
        int m;
        check({tag, "_count"}, q_data.size(), n);
        m = (q_data.size() < n) ? q_data.size() : n;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_data%0d", tag, i), q_data[i], i);
            check($sformatf("%s_user%0d", tag, i), q_user[i], i % 2);
            check($sformatf("%s_last%0d", tag, i), q_last[i], (i % 64) == 63);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tlast"},  tlast, 0);
        check({tag, "_tdata"},  tdata, 0);
        check({tag, "_tuser"},  tuser, 0);
        check({tag, "_ovf"},    overflow, 0);
        check({tag, "_drops"},  drop_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_b0, exp_b1, exp_z0;
        int k;
`ifdef AXIS_ADC_TEST_PATTEN_EN
        exp_b0 = 16'h0000; exp_b1 = 16'h0001; exp_z0 = 16'h0000;
`else
        exp_b0 = 16'hFFFF; exp_b1 = 16'h0002; exp_z0 = 16'h3FFF;
`endif
        rst = 1'b1; enable = 1'b1; adc_valid = 1'b0; adc_data = '0; tready = 1'b1;
        lfsr = 16'hACE1;

        // Reset state, first-frame latency, extension, enable falling mid-frame.
        reset_dut();
        check_idle_outputs("rst");
        check("tstrb", tstrb, 2'b11);
        check("tkeep", tkeep, 2'b11);
        adc_data  = {14'h0002, 14'h3FFF};
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        enable    = 1'b0;
        check("lat_n1_tvalid", tvalid, 0);
        step();
        check("lat_n2_tvalid", tvalid, 1);
        check("lat_n2_tdata", tdata, exp_b0);
        check("lat_n2_tuser", tuser, 0);
        check("zext_tdata", tdata_z, exp_z0);
        step();
        check("beat1_tvalid", tvalid, 1);
        check("beat1_tdata", tdata, exp_b1);
        check("beat1_tuser", tuser, 1);
        step();
        check("drained_tvalid", tvalid, 0);
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        repeat (2) step();
        check("disabled_tvalid", tvalid, 0);
        enable = 1'b1;

        // One full packet plus two beats at full throughput.
        reset_dut();
        clear_q();
        run_frames(33, 4, 1'b0);
        check_beats("pkt", 66);

        // Backpressure: 16 words fill the FIFO, one frame waits in the
        // serializer, the frame after it is dropped.
        reset_dut();
        clear_q();
        tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            adc_valid = (i % 4 == 0);
            adc_data  = frame_word(i / 4);
            step();
        end
        adc_valid = 1'b0;
        step();
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 1);
        check("ovf_tvalid", tvalid, 1);
        check("ovf_no_beats", q_data.size(), 0);
        tready = 1'b1;
        repeat (30) step();
        check_beats("ovf", 18);
        check("ovf_sticky", overflow, 1);

        // Reset in the middle of a packet.
        reset_dut();
        clear_q();
        k = 0;
        while (q_data.size() < 30 && k < 400) begin
            adc_valid = (k % 4 == 0);
            adc_data  = frame_word(k / 4);
            step();
            k++;
        end
        check("pre_rst_beats", q_data.size(), 30);
        adc_valid = 1'b0;
        rst = 1'b1;
        step();
        check_idle_outputs("midrst");
        rst = 1'b0;
        clear_q();
        run_frames(33, 4, 1'b0);
        check_beats("post_rst", 66);

        // Pseudo-random backpressure over several packets.
        reset_dut();
        clear_q();
        run_frames(130, 8, 1'b1);
        check_beats("lfsr", 260);
        check("lfsr_drops", drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
